cross_mul_arbiter: RTL and testbench
====================================

Name: cross_mul_arbiter

Overview:
- Shares one signed cross-product unit, R = ax*by - ay*bx, between several requesters in the geofence engine (e.g. the vertex angular-sort engine and the point-inside edge-test engine).
- Uses a single multiplier time-multiplexed over two cycles per job.
- Arbitrates with a round-robin pointer.
- Returns the result tagged with the requester id, plus sign flags used for ordering and inside/outside decisions.

Parameters:
- NREQ, 2, number of requesters, legal range 2..4.
- W, 11, signed operand width; each operand is a coordinate difference in the range -1024..1023.
- IDW, 2, width of res_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- ax  input  NREQ*W  packed signed operand ax; requester i uses slice [i*W +: W]. Same packing for ay, bx, by.
- ay  input  NREQ*W  packed signed operand ay.
- bx  input  NREQ*W  packed signed operand bx.
- by  input  NREQ*W  packed signed operand by.
- gnt  output  NREQ  one-hot, one-cycle accept pulse (registered).
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  one-cycle result strobe.
- res_id  output  IDW  index of the requester that owns the result.
- res_value  output  2W+1  signed result R.
- res_pos  output  1  R > 0.
- res_zero  output  1  R == 0.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer last = NREQ-1, so requester 0 wins first; operand and product registers are cleared.
- State machine, 4 states:
  - IDLE: if req != 0, pick the first requester with req set, searching last+1, last+2, ... modulo NREQ. Latch its four operands. Set gnt[id]=1 for the next cycle. Set last=id. Go to MUL1. If req == 0, stay in IDLE.
  - MUL1: p1 <= lat_ax * lat_by (signed, 2W bits). gnt is high during this cycle. Go to MUL2.
  - MUL2: res_value <= p1 - (lat_ay * lat_bx), sign-extended to 2W+1 bits. Go to DONE.
  - DONE: res_valid=1, with res_id, res_value, res_pos and res_zero stable for this cycle. Go to IDLE.
- Exactly one multiplier instance exists. Its operand mux is selected by state: (ax, by) in MUL1, (ay, bx) in MUL2.
- Latency: arbitration edge -> gnt cycle; res_valid follows 2 cycles after the gnt cycle (3 edges after acceptance).
- Throughput: one job per 4 cycles. Arbitration happens in IDLE only; requests raised while busy wait.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Deassert req no later than the cycle after gnt. A req still high in IDLE is treated as a new job.
  - Operands are latched at acceptance, so the requester may change them after gnt.
- Outside DONE, res_id, res_value, res_pos and res_zero hold their last values; only res_valid qualifies them.
- Simultaneous requests: strict round-robin, no starvation. With all NREQ requesters asserting continuously, each is served once per NREQ jobs.
- A request that drops before it is granted is never served. No error is flagged.
- Arithmetic: all operations are two's-complement signed. There is no overflow: |R| <= 2*2^(2W-2) fits in 2W+1 bits.
- Reset mid-job: the job is abandoned immediately; no res_valid or gnt is produced afterwards for it; the pointer returns to NREQ-1.
- Bits of req above NREQ-1 do not exist. There is no X-propagation dependency on unselected operand slices.

Test Plan:
- Single job: after reset, req=01, requester 0 with ax=3, ay=4, bx=5, by=6 -> gnt=01 one cycle; 3 edges later res_valid=1, res_id=0, res_value=-2, res_pos=0, res_zero=0.
- Extreme operands: ax=-1024, by=-1024, ay=1023, bx=-1024 -> res_value=2096128, res_pos=1. Also ax=by=ay=bx=-1024 -> res_value=0, res_zero=1.
- Contention: both requesters hold req continuously from reset -> grant order 0,1,0,1; res_valid spaced exactly 4 cycles apart; res_id alternates.
- Late request: req1 raised while a job for requester 0 is in MUL1 -> no gnt until IDLE; then gnt=10.
- Operand change after gnt: requester 0 alters ax in MUL2 -> result still uses the latched values.
- Reset asserted during MUL2 -> busy=0 and res_valid=0 immediately. After release with req=11, the first grant goes to requester 0.

Source files
------------

// File: rtl/cross_mul_arbiter.sv
// Shared signed cross-product unit R = ax*by - ay*bx with round-robin arbitration.
// One multiplier is reused over two cycles per job; results return tagged with the requester id.
module cross_mul_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 11,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*W-1:0]     ax,
  input  logic [NREQ*W-1:0]     ay,
  input  logic [NREQ*W-1:0]     bx,
  input  logic [NREQ*W-1:0]     by,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic signed [2*W:0]   res_value,
  output logic                  res_pos,
  output logic                  res_zero
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned RW = 2 * W + 1;

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t                state, state_nx;
  logic [IDW-1:0]        last;
  logic [IDW-1:0]        pick;
  logic                  found;
  logic                  accept;
  logic [NREQ-1:0]       gnt_nx;
  logic signed [W-1:0]   sel_ax, sel_ay, sel_bx, sel_by;
  logic signed [W-1:0]   lat_ax, lat_ay, lat_bx, lat_by;
  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  p1;
  logic signed [RW-1:0]  diff;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = MUL1;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Round-robin search starting after the last winner, plus operand select for the winner
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    gnt_nx = '0;
    sel_ax = '0;
    sel_ay = '0;
    sel_bx = '0;
    sel_by = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if (!found && req[j] && (j == (int'(last) + k) % int'(NREQ))) begin
          found = 1'b1;
          pick  = IDW'(j);
        end
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (found && (int'(pick) == j)) begin
        gnt_nx[j] = 1'b1;
        sel_ax    = ax[j*W +: W];
        sel_ay    = ay[j*W +: W];
        sel_bx    = bx[j*W +: W];
        sel_by    = by[j*W +: W];
      end
    end
  end

  // Output decode: acceptance and the state-selected multiplier operands
  always_comb begin
    accept = (state == IDLE) && found;
    mul_a  = (state == MUL1) ? lat_ax : lat_ay;
    mul_b  = (state == MUL1) ? lat_by : lat_bx;
  end

  assign prod = mul_a * mul_b;
  assign diff = RW'(p1) - RW'(prod);

  // Datapath and registered outputs; last doubles as the id of the job in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_value <= '0;
      res_pos   <= 1'b0;
      res_zero  <= 1'b0;
      last      <= IDW'(NREQ - 1);
      lat_ax    <= '0;
      lat_ay    <= '0;
      lat_bx    <= '0;
      lat_by    <= '0;
      p1        <= '0;
    end else begin
      gnt       <= accept ? gnt_nx : '0;
      busy      <= (state_nx != IDLE);
      res_valid <= (state == MUL2);
      if (accept) begin
        last   <= pick;
        lat_ax <= sel_ax;
        lat_ay <= sel_ay;
        lat_bx <= sel_bx;
        lat_by <= sel_by;
      end
      if (state == MUL1) p1 <= prod;
      if (state == MUL2) begin
        res_id    <= last;
        res_value <= diff;
        res_pos   <= !diff[RW-1] && (|diff);
        res_zero  <= ~|diff;
      end
    end
  end

endmodule

// File: tb/tb_cross_mul_arbiter.sv
// Self-checking bench for cross_mul_arbiter: vector table, scoreboard of expected results,
// and directed sequences for contention, late requests and reset mid-job.
module tb_cross_mul_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 11;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    ax, ay, bx, by;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic signed [2*W:0]  res_value;
  logic                 res_pos;
  logic                 res_zero;

  cross_mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .ax(ax), .ay(ay), .bx(bx), .by(by),
    .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_value(res_value), .res_pos(res_pos), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    int     a_x;
    int     a_y;
    int     b_x;
    int     b_y;
    longint exp;
  } vec_t;

  typedef struct {
    int     id;
    longint val;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model(input int a_x, input int a_y, input int b_x, input int b_y);
    return longint'(a_x) * longint'(b_y) - longint'(a_y) * longint'(b_x);
  endfunction

  task automatic set_ops(input int id, input int a_x, input int a_y, input int b_x, input int b_y);
    ax[id*W +: W] = W'(a_x);
    ay[id*W +: W] = W'(a_y);
    bx[id*W +: W] = W'(b_x);
    by[id*W +: W] = W'(b_y);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(2047)) - 1024;
  endfunction

  task automatic scramble(input int id);
    set_ops(id, rnd_op(), rnd_op(), rnd_op(), rnd_op());
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g  = gnt;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant within 20 cycles, required a grant");
    end
  endtask

  // Scoreboard: every result strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d value=%0d, required no result", res_id, res_value);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("res_id", longint'(res_id), longint'(e.id));
        check("res_value", longint'(res_value), e.val);
        check("res_pos", longint'(res_pos), longint'(e.val > 0));
        check("res_zero", longint'(res_zero), longint'(e.val == 0));
      end
    end
  end

  // One isolated job; operands are scrambled after the grant to prove they were latched
  task automatic do_job(input vec_t v);
    logic [NREQ-1:0] g;
    bit ok;
    @(negedge clk);
    set_ops(v.id, v.a_x, v.a_y, v.b_x, v.b_y);
    req[v.id] = 1'b1;
    sbq.push_back('{v.id, v.exp});
    wait_gnt(g, ok);
    req[v.id] = 1'b0;
    if (!ok) begin
      sbq.delete();
      return;
    end
    check("job_gnt", longint'(g), longint'(1 << v.id));
    scramble(v.id);
    @(negedge clk);
    check("job_valid_mul2", longint'(res_valid), 0);
    check("job_busy", longint'(busy), 1);
    scramble(v.id);
    @(negedge clk);
    check("job_valid_done", longint'(res_valid), 1);
    @(negedge clk);
    check("job_idle", longint'(busy), 0);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    bit ok;
    int ng, nv, prev;

    vecs[0] = '{0,     3,     4,     5,     6,       -2};
    vecs[1] = '{0, -1024,  1023, -1024, -1024,  2096128};
    vecs[2] = '{1, -1024, -1024, -1024, -1024,        0};
    vecs[3] = '{1, -1024, -1024, -1024,  1023, -2096128};
    vecs[4] = '{0,  1023, -1024,  1023,  1023,  2094081};
    vecs[5] = '{1,     7,    -3,     2,    -5,      -29};
    vecs[6] = '{0, -1024,  1023,  1023, -1024,     2047};
    vecs[7] = '{1,    -1,     1,     1,    -1,        0};

    reset = 1'b1;
    req   = '0;
    ax = '0; ay = '0; bx = '0; by = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", longint'(gnt), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(res_valid), 0);
    check("rst_value", longint'(res_value), 0);
    check("rst_flags", longint'({res_id, res_pos, res_zero}), 0);

    // Contention from reset: strict alternation, results 4 cycles apart
    set_ops(0, 3, 4, 5, 6);
    set_ops(1, 7, -3, 2, -5);
    req = 2'b11;
    for (int i = 0; i < 4; i++) sbq.push_back('{i % 2, (i % 2 == 0) ? model(3, 4, 5, 6) : model(7, -3, 2, -5)});
    @(negedge clk);
    reset = 1'b0;
    ng = 0; nv = 0; prev = -1;
    for (int c = 0; c < 60 && nv < 4; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        check("cont_gnt_order", longint'(gnt), (ng % 2 == 0) ? 1 : 2);
        ng++;
      end
      if (res_valid) begin
        if (prev >= 0) check("cont_spacing", longint'(c - prev), 4);
        prev = c;
        nv++;
      end
    end
    req = '0;
    check("cont_results", longint'(nv), 4);
    @(negedge clk);
    check("cont_idle", longint'(busy), 0);

    for (int i = 0; i < 8; i++) do_job(vecs[i]);

    // Late request from requester 1 while requester 0 is in MUL1
    @(negedge clk);
    set_ops(0, 10, 20, 30, 40);
    req = 2'b01;
    sbq.push_back('{0, -200});
    wait_gnt(g, ok);
    check("late_first_gnt", longint'(g), 1);
    req = 2'b10;
    set_ops(1, -5, 6, 7, -8);
    sbq.push_back('{1, -2});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_no_gnt", longint'(gnt), 0);
    end
    @(negedge clk);
    check("late_second_gnt", longint'(gnt), 2);
    req = '0;
    repeat (3) @(negedge clk);
    check("late_idle", longint'(busy), 0);

    // Reset during MUL2 abandons the job and restores the pointer
    set_ops(0, 100, 2, 3, 50);
    set_ops(1, 9, 9, 9, 9);
    req = 2'b11;
    sbq.push_back('{0, model(100, 2, 3, 50)});
    wait_gnt(g, ok);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_valid", longint'(res_valid), 0);
    check("midrst_gnt", longint'(gnt), 0);
    req = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back('{0, model(100, 2, 3, 50)});
    wait_gnt(g, ok);
    req = '0;
    check("midrst_first_gnt", longint'(g), 1);
    repeat (3) @(negedge clk);
    check("midrst_idle", longint'(busy), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", longint'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
